// File: rtl/ex_mem_if.sv
// EX/MEM pipeline-register bus: EX-stage inputs, WB forwarding inputs, and
// memory-facing / MEM-WB-facing outputs.
interface ex_mem_if #(parameter int CNT_W = 32);
  logic             stall;
  logic             flush;
  logic             idex_valid;
  logic [63:0]      idex_alu_result;
  logic [63:0]      idex_rs2_data;
  logic [4:0]       idex_rs2;
  logic [4:0]       idex_rd;
  logic             idex_regwrite;
  logic             idex_memtoreg;
  logic             idex_memread;
  logic             idex_memwrite;
  logic             wb_regwrite;
  logic [4:0]       wb_rd;
  logic [63:0]      wb_data;
  logic [63:0]      address;
  logic [63:0]      write_data;
  logic             exmem_read;
  logic             exmem_write;
  logic             exmem_valid;
  logic [63:0]      exmem_alu_result;
  logic [4:0]       exmem_rd;
  logic             exmem_regwrite;
  logic             exmem_memtoreg;
  logic             exmem_fault;
  logic [CNT_W-1:0] load_count;
  logic [CNT_W-1:0] store_count;

  modport master (
    output stall, flush, idex_valid, idex_alu_result, idex_rs2_data, idex_rs2,
           idex_rd, idex_regwrite, idex_memtoreg, idex_memread, idex_memwrite,
           wb_regwrite, wb_rd, wb_data,
    input  address, write_data, exmem_read, exmem_write, exmem_valid,
           exmem_alu_result, exmem_rd, exmem_regwrite, exmem_memtoreg,
           exmem_fault, load_count, store_count
  );

  modport slave (
    input  stall, flush, idex_valid, idex_alu_result, idex_rs2_data, idex_rs2,
           idex_rd, idex_regwrite, idex_memtoreg, idex_memread, idex_memwrite,
           wb_regwrite, wb_rd, wb_data,
    output address, write_data, exmem_read, exmem_write, exmem_valid,
           exmem_alu_result, exmem_rd, exmem_regwrite, exmem_memtoreg,
           exmem_fault, load_count, store_count
  );
endinterface

// File: rtl/ex_mem_register.sv
// EX/MEM pipeline register: stall/flush control, WB store-data forwarding,
// out-of-range fault detection and load/store event counters.
module ex_mem_register #(
  parameter int ADDR_LIMIT = 256,
  parameter int CNT_W      = 32
) (
  input  logic      clk,
  input  logic      rst,
  ex_mem_if.slave   bus
);
  localparam logic [63:0] LIMIT = 64'(ADDR_LIMIT);

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memtoreg;
    logic        memread;
    logic        memwrite;
  } ctrl_t;

  typedef struct packed {
    logic [63:0] alu_result;
    logic [63:0] wdata;
    logic [4:0]  rd;
  } data_t;

  ctrl_t            ctrl_q, ctrl_d;
  data_t            data_q, data_d;
  logic             fault_q;
  logic [CNT_W-1:0] load_cnt_q, store_cnt_q;
  logic             fwd_hit, access, fault_now, capture;

  assign capture   = !bus.flush && !bus.stall;
  assign fwd_hit   = bus.wb_regwrite && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.idex_rs2);
  assign access    = bus.idex_valid && (bus.idex_memread || bus.idex_memwrite);
  assign fault_now = access && (bus.idex_alu_result >= LIMIT);

  // An out-of-range access keeps its writeback controls but never reaches memory.
  always_comb begin
    ctrl_d          = '0;
    ctrl_d.valid    = bus.idex_valid;
    ctrl_d.regwrite = bus.idex_valid && bus.idex_regwrite;
    ctrl_d.memtoreg = bus.idex_valid && bus.idex_memtoreg;
    ctrl_d.memread  = bus.idex_valid && bus.idex_memread  && !fault_now;
    ctrl_d.memwrite = bus.idex_valid && bus.idex_memwrite && !fault_now;
    data_d.alu_result = bus.idex_alu_result;
    data_d.wdata      = fwd_hit ? bus.wb_data : bus.idex_rs2_data;
    data_d.rd         = bus.idex_rd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q      <= '0;
      data_q      <= '0;
      fault_q     <= 1'b0;
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else if (bus.flush) begin
      ctrl_q <= '0;
    end else if (capture) begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
      if (fault_now)       fault_q     <= 1'b1;
      if (ctrl_d.memread)  load_cnt_q  <= load_cnt_q + CNT_W'(1);
      if (ctrl_d.memwrite) store_cnt_q <= store_cnt_q + CNT_W'(1);
    end
  end

  assign bus.address          = data_q.alu_result;
  assign bus.write_data       = data_q.wdata;
  assign bus.exmem_read       = ctrl_q.memread;
  assign bus.exmem_write      = ctrl_q.memwrite;
  assign bus.exmem_valid      = ctrl_q.valid;
  assign bus.exmem_alu_result = data_q.alu_result;
  assign bus.exmem_rd         = data_q.rd;
  assign bus.exmem_regwrite   = ctrl_q.regwrite;
  assign bus.exmem_memtoreg   = ctrl_q.memtoreg;
  assign bus.exmem_fault      = fault_q;
  assign bus.load_count       = load_cnt_q;
  assign bus.store_count      = store_cnt_q;
endmodule
